arb_mux_rr: RTL and testbench

//   Registered N-channel data multiplexer with round-robin arbitration and valid/ready handshakes.
//   - Generalises the ALU's 4:1 result-select mux: parametrised width and channel count.
//   - Sequential select replaces the external static select.
//   - Sits between ALU functional units and the shared result bus; exactly one channel wins per transfer.

---
 rtl/arb_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/arb_mux_rr.sv | 87 ++++++++
 tb/tb_arb_mux_rr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared defaults and the round-robin wrap increment for the arbitrated result mux.
// Pure declarations: no latency, no backpressure.
// Used by rr_arbiter and arb_mux_rr.
package arb_mux_pkg;

    localparam int ARB_MUX_WIDTH_DEF = 8;
    localparam int ARB_MUX_CH_DEF    = 4;

    // Next channel index after idx, wrapping n-1 back to 0 (n need not be a power of two).
    function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter: first active request searching ptr, ptr+1, ... with wrap.
// Latency: combinational. Backpressure: none; the caller gates the grant with its load enable.
// Optional fixed-priority input when ARB_MUX_PRIO_EN is defined.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int CHANNELS = ARB_MUX_CH_DEF,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
`ifdef ARB_MUX_PRIO_EN
    input  logic                prio,
`endif
    output logic [SEL_W-1:0]    grant,
    output logic                any_req
);

    // One extra bit so ptr + offset never overflows before the wrap subtraction.
    localparam int IW = SEL_W + 1;

    logic [IW-1:0] w_start;

    always_comb begin
        w_start = {1'b0, ptr};
`ifdef ARB_MUX_PRIO_EN
        if (prio) w_start = '0;
`endif
    end

    always_comb begin
        logic [IW-1:0] w_idx;
        grant   = '0;
        any_req = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = w_start + IW'(k);
            if (w_idx >= IW'(CHANNELS)) w_idx = w_idx - IW'(CHANNELS);
            if (!any_req && req[w_idx[SEL_W-1:0]]) begin
                grant   = w_idx[SEL_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_rr.sv
// Registered N-channel result mux with round-robin arbitration (fixed priority via ARB_MUX_PRIO_EN).
// Latency: 1 clk from input accept to out_valid; one word per clk when out_ready stays high.
// Backpressure: single-entry output register, loads when empty or draining; in_ready is one-hot or zero.
module arb_mux_rr
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH    = ARB_MUX_WIDTH_DEF,
    parameter  int CHANNELS = ARB_MUX_CH_DEF,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
`ifdef ARB_MUX_PRIO_EN
    input  logic                      prio_mode,
`endif
    input  logic                      out_ready
);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_ld;
    logic                w_any;
    logic [SEL_W-1:0]    w_grant;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]    w_win_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req      (in_valid),
        .ptr      (r_ptr),
`ifdef ARB_MUX_PRIO_EN
        .prio     (prio_mode),
`endif
        .grant    (w_grant),
        .any_req  (w_any)
    );

    assign w_ld      = ~r_out_valid | out_ready;
    assign w_ptr_nxt = SEL_W'(rr_next(32'(w_grant), 32'(CHANNELS)));

    // Ready depends only on valids, pointer and output state, never on data.
    assign in_ready  = (~rst & w_ld & w_any) ? (CHANNELS'(1) << w_grant) : '0;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) w_win_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_ld) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_out_sel   <= w_grant;
`ifdef ARB_MUX_PRIO_EN
                if (!prio_mode) r_ptr <= w_ptr_nxt;
`else
                r_ptr       <= w_ptr_nxt;
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr: a 4-channel instance and a 3-channel instance sharing clk/rst.
module tb_arb_mux_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  a_in_valid;
    logic [31:0] a_in_data;
    logic [3:0]  a_in_ready;
    logic        a_out_valid;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_sel;
    logic        a_out_ready;
`ifdef ARB_MUX_PRIO_EN
    logic        a_prio_mode;
    logic        b_prio_mode;
`endif

    logic [2:0]  b_in_valid;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_sel;
    logic        b_out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_d [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

    always #5 clk = ~clk;

    arb_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
`ifdef ARB_MUX_PRIO_EN
        .prio_mode (a_prio_mode),
`endif
        .out_ready (a_out_ready)
    );

    arb_mux_rr #(.WIDTH(8), .CHANNELS(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
`ifdef ARB_MUX_PRIO_EN
        .prio_mode (b_prio_mode),
`endif
        .out_ready (b_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = '0;
        a_in_data   = '0;
        a_out_ready = 1'b0;
        b_in_valid  = '0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
`ifdef ARB_MUX_PRIO_EN
        a_prio_mode = 1'b0;
        b_prio_mode = 1'b0;
`endif
        tick();
        chk("reset_valid", 32'(a_out_valid), 32'h0);
        chk("reset_data",  32'(a_out_data),  32'h0);
        chk("reset_sel",   32'(a_out_sel),   32'h0);

        // Test 1: word 0xA5 held under backpressure, then reset
        rst        = 1'b0;
        a_in_valid = 4'b0100;
        a_in_data  = 32'h00A5_0000;
        tick();
        chk("t1_load_valid", 32'(a_out_valid), 32'h1);
        chk("t1_load_data",  32'(a_out_data),  32'hA5);
        chk("t1_load_sel",   32'(a_out_sel),   32'h2);
        a_in_valid = 4'b1111;
        rst        = 1'b1;
        #1;
        chk("t1_ready_in_rst", 32'(a_in_ready), 32'h0);
        tick();
        rst = 1'b0;
        a_in_valid = 4'b0000;
        #1;
        chk("t1_rst_valid", 32'(a_out_valid), 32'h0);
        chk("t1_rst_data",  32'(a_out_data),  32'h0);
        chk("t1_rst_sel",   32'(a_out_sel),   32'h0);

        // Test 2: all valid, round-robin 0,1,2,3,0 at one word per clock
        a_in_data   = 32'h4332_2110;
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_in_ready", 32'(a_in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("t2_valid", 32'(a_out_valid), 32'h1);
            chk("t2_sel",   32'(a_out_sel),   32'(k % 4));
            chk("t2_data",  32'(a_out_data),  32'(exp_d[k % 4]));
        end
        a_in_valid = 4'b0000;
        tick();
        chk("t2_idle_valid", 32'(a_out_valid), 32'h0);
        chk("t2_idle_data",  32'(a_out_data),  32'h10);
        chk("t2_idle_sel",   32'(a_out_sel),   32'h0);

        // Test 3: backpressure with ch2 (ptr is 1 here)
        a_out_ready = 1'b0;
        a_in_valid  = 4'b0100;
        a_in_data   = 32'h007E_0000;
        #1;
        chk("t3_first_ready", 32'(a_in_ready), 32'h4);
        tick();
        chk("t3_load_data", 32'(a_out_data), 32'h7E);
        a_in_data = 32'h0081_0000;
        for (int k = 0; k < 3; k++) begin
            chk("t3_stall_ready", 32'(a_in_ready), 32'h0);
            chk("t3_stall_valid", 32'(a_out_valid), 32'h1);
            chk("t3_stall_data",  32'(a_out_data),  32'h7E);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(a_in_ready), 32'h4);
        tick();
        chk("t3_next_valid", 32'(a_out_valid), 32'h1);
        chk("t3_next_data",  32'(a_out_data),  32'h81);
        chk("t3_next_sel",   32'(a_out_sel),   32'h2);
        a_in_valid = 4'b0000;
        tick();
        chk("t3_drain_valid", 32'(a_out_valid), 32'h0);

        // Test 5: sparse request from ch3 with ptr=0
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        a_in_valid = 4'b1000;
        a_in_data  = 32'hFF00_0000;
        #1;
        chk("t5_in_ready", 32'(a_in_ready), 32'h8);
        tick();
        chk("t5_sel",  32'(a_out_sel),  32'h3);
        chk("t5_data", 32'(a_out_data), 32'hFF);
        a_in_valid = 4'b1111;
        #1;
        chk("t5_ptr_wrapped", 32'(a_in_ready), 32'h1);
        a_in_valid = 4'b0000;
        tick();

        // Test 4: three channels, wrap from ptr=2 back to 0
        b_in_data  = 24'h2C_11_0A;
        b_in_valid = 3'b010;
        tick();
        chk("t4_ch1_sel", 32'(b_out_sel), 32'h1);
        b_in_valid = 3'b101;
        #1;
        chk("t4_ready_ch2", 32'(b_in_ready), 32'h4);
        tick();
        chk("t4_ch2_sel",  32'(b_out_sel),  32'h2);
        chk("t4_ch2_data", 32'(b_out_data), 32'h2C);
        chk("t4_ready_ch0", 32'(b_in_ready), 32'h1);
        tick();
        chk("t4_ch0_sel",  32'(b_out_sel),  32'h0);
        chk("t4_ch0_data", 32'(b_out_data), 32'h0A);
        chk("t4_ready_after_wrap", 32'(b_in_ready), 32'h4);
        b_in_valid = 3'b000;
        tick();
        chk("t4_idle_valid", 32'(b_out_valid), 32'h0);

`ifdef ARB_MUX_PRIO_EN
        // Test 6: fixed priority holds ptr, round-robin resumes from it
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        a_in_data  = 32'h4332_2110;
        a_in_valid = 4'b0010;
        tick();
        chk("t6_setup_sel", 32'(a_out_sel), 32'h1);
        a_prio_mode = 1'b1;
        a_in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_prio_ready", 32'(a_in_ready), 32'h1);
            tick();
            chk("t6_prio_sel",  32'(a_out_sel),  32'h0);
            chk("t6_prio_data", 32'(a_out_data), 32'h10);
        end
        a_prio_mode = 1'b0;
        #1;
        chk("t6_rr_ready", 32'(a_in_ready), 32'h4);
        tick();
        chk("t6_rr_sel", 32'(a_out_sel), 32'h2);
        a_in_valid = 4'b0000;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
